tpu_host_seq: RTL and testbench

//  Bus initiator for the tpuv1 memory-mapped TPU: drives r_w/addr/dataIn and samples dataOut.

---
 rtl/tpu_pkg.sv | 30 +++
 rtl/tpu_host_seq_if.sv | 36 +++
 rtl/tpu_host_seq.sv | 186 ++++++++++++++++++
 tb/tb_tpu_host_seq.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared tpuv1 definitions: bus address map, C row layout and the host sequencer state encoding.
package tpu_pkg;

    localparam int TPU_DIM = 8;

    localparam logic [15:0] TPU_A_BASE  = 16'h0100;
    localparam logic [15:0] TPU_B_BASE  = 16'h0200;
    localparam logic [15:0] TPU_C_BASE  = 16'h0300;
    localparam logic [15:0] TPU_MM_ADDR = 16'h0400;

    // One C row is two bus words (elements 0-3, then 4-7)
    localparam int C_ROW_STRIDE = 16;

    localparam int MATMUL_CYCLES = 3 * TPU_DIM - 2;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD_A,
        ST_LOAD_B,
        ST_LOAD_C,
        ST_KICK,
        ST_WAIT,
        ST_RD_ADDR,
        ST_RD_LAT,
        ST_CAPTURE,
        ST_OUT,
        ST_DONE
    } tpu_seq_state_e;

endpackage

// File: rtl/tpu_host_seq_if.sv
// Operand stream in, C result stream out, and the tpuv1 r_w/addr/dataIn/dataOut bus.
interface tpu_host_seq_if #(
    parameter int DATAW = 64,
    parameter int ADDRW = 16
);
    logic [DATAW-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    logic [DATAW-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    logic             bus_r_w;
    logic [ADDRW-1:0] bus_addr;
    logic [DATAW-1:0] bus_wdata;
    logic [DATAW-1:0] bus_rdata;

    modport master (
        input  in_data, in_valid,
        output in_ready,
        output out_data, out_valid,
        input  out_ready,
        output bus_r_w, bus_addr, bus_wdata,
        input  bus_rdata
    );

    modport slave (
        output in_data, in_valid,
        input  in_ready,
        input  out_data, out_valid,
        output out_ready,
        input  bus_r_w, bus_addr, bus_wdata,
        output bus_rdata
    );
endinterface

// File: rtl/tpu_host_seq.sv
// tpu_host_seq: streams A/B/C operands into tpuv1, kicks MatMul, reads C back as a stream.
// Build option TPU_SEQ_PERF_EN adds perf_cycles, a saturating count of busy cycles per job.
module tpu_host_seq
    import tpu_pkg::*;
#(
    parameter int DIM     = 8,
    parameter int DATAW   = 64,
    parameter int ADDRW   = 16,
    parameter int RD_LAT  = 1,
    parameter int MM_WAIT = 3 * DIM
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    output logic           busy,
    output logic           done,
    tpu_host_seq_if.master io
`ifdef TPU_SEQ_PERF_EN
    ,
    output logic [31:0]    perf_cycles
`endif
);

    localparam int WORD_W = $clog2(2 * DIM);
    localparam int WAIT_W = $clog2(MM_WAIT + RD_LAT + 1);

    localparam logic [WORD_W-1:0] LAST_AB   = WORD_W'(DIM - 1);
    localparam logic [WORD_W-1:0] LAST_C    = WORD_W'(2 * DIM - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MM_WAIT - 1);
    localparam logic [WAIT_W-1:0] LAT_LAST  = WAIT_W'((RD_LAT > 1) ? RD_LAT - 2 : 0);

    tpu_seq_state_e    state_q, state_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [DATAW-1:0]  out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;

    logic [ADDRW-1:0]  load_addr;
    logic [ADDRW-1:0]  c_addr;
    logic              phase_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            word_q      <= '0;
            wait_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            wait_q      <= wait_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    // C words interleave lo/hi per row, so word index w maps to row w/2, half w%2
    always_comb begin
        c_addr = ADDRW'(TPU_C_BASE)
               + ADDRW'(int'(word_q >> 1) * C_ROW_STRIDE)
               + ADDRW'(int'(word_q[0]) * 8);
        load_addr = c_addr;
        if (state_q == ST_LOAD_A) begin
            load_addr = ADDRW'(TPU_A_BASE) + ADDRW'({word_q, 3'b000});
        end else if (state_q == ST_LOAD_B) begin
            load_addr = ADDRW'(TPU_B_BASE) + ADDRW'({word_q, 3'b000});
        end
        phase_last = (state_q == ST_LOAD_C) ? (word_q == LAST_C) : (word_q == LAST_AB);
    end

    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        wait_d       = wait_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        io.in_ready  = 1'b0;
        io.bus_r_w   = 1'b0;
        io.bus_addr  = '0;
        io.bus_wdata = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD_A;
                    word_d  = '0;
                end
            end
            ST_LOAD_A, ST_LOAD_B, ST_LOAD_C: begin
                io.in_ready = 1'b1;
                if (io.in_valid) begin
                    io.bus_r_w   = 1'b1;
                    io.bus_addr  = load_addr;
                    io.bus_wdata = io.in_data;
                    word_d       = word_q + WORD_W'(1);
                    if (phase_last) begin
                        word_d = '0;
                        case (state_q)
                            ST_LOAD_A: state_d = ST_LOAD_B;
                            ST_LOAD_B: state_d = ST_LOAD_C;
                            default:   state_d = ST_KICK;
                        endcase
                    end
                end
            end
            ST_KICK: begin
                io.bus_r_w  = 1'b1;
                io.bus_addr = ADDRW'(TPU_MM_ADDR);
                state_d     = ST_WAIT;
                wait_d      = '0;
            end
            ST_WAIT: begin
                wait_d = wait_q + WAIT_W'(1);
                if (wait_q == WAIT_LAST) begin
                    state_d = ST_RD_ADDR;
                end
            end
            ST_RD_ADDR: begin
                io.bus_addr = c_addr;
                wait_d      = '0;
                state_d     = (RD_LAT > 1) ? ST_RD_LAT : ST_CAPTURE;
            end
            ST_RD_LAT: begin
                io.bus_addr = c_addr;
                wait_d      = wait_q + WAIT_W'(1);
                if (wait_q == LAT_LAST) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                out_data_d  = io.bus_rdata;
                out_valid_d = 1'b1;
                state_d     = ST_OUT;
            end
            ST_OUT: begin
                // Next read is only issued once the held word has been taken
                if (io.out_ready) begin
                    out_valid_d = 1'b0;
                    if (word_q == LAST_C) begin
                        word_d  = '0;
                        state_d = ST_DONE;
                    end else begin
                        word_d  = word_q + WORD_W'(1);
                        state_d = ST_RD_ADDR;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy         = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done         = (state_q == ST_DONE);
    assign io.out_data  = out_data_q;
    assign io.out_valid = out_valid_q;

`ifdef TPU_SEQ_PERF_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (state_q == ST_IDLE && start) begin
            perf_d = '0;
        end else if (busy && perf_q != 32'hFFFF_FFFF) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_tpu_host_seq.sv
// Scoreboard bench for tpu_host_seq with a behavioural tpuv1 model on the bus.
module tb_tpu_host_seq;
    import tpu_pkg::*;

    localparam int DIM     = 8;
    localparam int MM_WAIT = 3 * DIM;
    localparam int NWORDS  = 4 * DIM;

    typedef struct packed {
        logic [15:0] a;
        logic [63:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy;
    logic done;
`ifdef TPU_SEQ_PERF_EN
    logic [31:0] perf_cycles;
`endif

    tpu_host_seq_if #(.DATAW(64), .ADDRW(16)) bus_if ();

    tpu_host_seq #(
        .DIM(DIM), .DATAW(64), .ADDRW(16), .RD_LAT(1), .MM_WAIT(MM_WAIT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .busy(busy),
        .done(done),
        .io(bus_if)
`ifdef TPU_SEQ_PERF_EN
        , .perf_cycles(perf_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int out_cnt = 0;
    int done_cnt = 0;
    int busy_cyc = 0;
    int idle_cnt = 0;
    int bp_idx = -1;
    int bp_left = 0;
    int d0 = 0;
    bit kick_seen = 1'b0;

    wr_t         exp_wr[$];
    logic [15:0] exp_rd[$];
    logic [63:0] exp_out[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
        end
    endtask

    task automatic extra(input string nm, input logic [63:0] act);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got 0x%0h, required nothing", nm, act);
    endtask

    // ---------------- tpuv1 behavioural model ----------------
    logic [63:0] a_m[DIM];
    logic [63:0] b_m[DIM];
    logic [63:0] c_m[2*DIM];

    function automatic logic [63:0] mm_word(input int w);
        logic [63:0] r;
        logic [15:0] acc;
        int i, j;
        r = '0;
        i = w / 2;
        for (int e = 0; e < 4; e++) begin
            j = (w % 2) * 4 + e;
            acc = c_m[w][16*e +: 16];
            for (int k = 0; k < DIM; k++) begin
                acc = acc + 16'(a_m[i][8*k +: 8]) * 16'(b_m[k][8*j +: 8]);
            end
            r[16*e +: 16] = acc;
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (bus_if.bus_r_w) begin
            case (bus_if.bus_addr[11:8])
                4'h1: a_m[bus_if.bus_addr[5:3]] <= bus_if.bus_wdata;
                4'h2: b_m[bus_if.bus_addr[5:3]] <= bus_if.bus_wdata;
                4'h3: c_m[bus_if.bus_addr[6:3]] <= bus_if.bus_wdata;
                4'h4: for (int w = 0; w < 2*DIM; w++) c_m[w] <= mm_word(w);
                default: ;
            endcase
        end
        bus_if.bus_rdata <= (bus_if.bus_addr[11:8] == 4'h3) ? c_m[bus_if.bus_addr[6:3]] : 64'h0;
    end

    // ---------------- stimulus tables ----------------
    function automatic logic [63:0] in_word(input int pat, input int i);
        if (i < DIM) return (pat == 0 ? 64'h1 : 64'h2) << (8 * i);
        if (i < 2*DIM) return (pat == 0) ? 64'h0101_0101_0101_0101 : 64'h0102_0304_0506_0708;
        return (pat == 0) ? 64'h0 : 64'h0001_0001_0001_0001;
    endfunction

    function automatic logic [15:0] wr_addr(input int i);
        if (i < DIM) return 16'h0100 + 16'(8 * i);
        if (i < 2*DIM) return 16'h0200 + 16'(8 * (i - DIM));
        return 16'h0300 + 16'(8 * (i - 2*DIM));
    endfunction

    function automatic logic [63:0] c_word(input int pat, input int k);
        if (pat == 0) return 64'h0001_0001_0001_0001;
        return (k % 2 == 0) ? 64'h000b_000d_000f_0011 : 64'h0003_0005_0007_0009;
    endfunction

    // ---------------- consumer: out_ready with optional stall ----------------
    initial begin
        bus_if.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bus_if.out_valid && out_cnt == bp_idx && bp_left > 0) begin
                bus_if.out_ready = 1'b0;
                bp_left--;
            end else begin
                bus_if.out_ready = 1'b1;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        bit rd, prev_rd, hold_prev;
        logic [63:0] held;
        wr_t e;
        prev_rd = 1'b0;
        hold_prev = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                kick_seen = 1'b0;
                prev_rd   = 1'b0;
                hold_prev = 1'b0;
                idle_cnt  = 0;
            end else begin
                if (busy) busy_cyc++;
                rd = !bus_if.bus_r_w && (bus_if.bus_addr != 16'h0);
                if (bus_if.bus_r_w) begin
                    if (bus_if.bus_addr != TPU_MM_ADDR)
                        chk("wr_handshake", 64'(bus_if.in_valid & bus_if.in_ready), 64'h1);
                    if (exp_wr.size() == 0) begin
                        extra("wr_extra", 64'(bus_if.bus_addr));
                    end else begin
                        e = exp_wr.pop_front();
                        chk("wr_addr", 64'(bus_if.bus_addr), 64'(e.a));
                        chk("wr_data", bus_if.bus_wdata, e.d);
                    end
                    if (bus_if.bus_addr == TPU_MM_ADDR) begin
                        kick_seen = 1'b1;
                        idle_cnt  = 0;
                    end
                end else if (rd) begin
                    if (!prev_rd) begin
                        chk("rd_no_outstanding", 64'(bus_if.out_valid), 64'h0);
                        if (kick_seen) begin
                            chk("mm_wait_idle", 64'(idle_cnt), 64'(MM_WAIT));
                            kick_seen = 1'b0;
                        end
                        if (exp_rd.size() == 0) extra("rd_extra", 64'(bus_if.bus_addr));
                        else chk("rd_addr", 64'(bus_if.bus_addr), 64'(exp_rd.pop_front()));
                    end
                end else if (kick_seen) begin
                    idle_cnt++;
                end
                prev_rd = rd;

                if (hold_prev) begin
                    chk("out_valid_held", 64'(bus_if.out_valid), 64'h1);
                    chk("out_stable", bus_if.out_data, held);
                end
                hold_prev = 1'b0;
                if (bus_if.out_valid) begin
                    if (bus_if.out_ready) begin
                        if (exp_out.size() == 0) extra("out_extra", bus_if.out_data);
                        else chk("out_data", bus_if.out_data, exp_out.pop_front());
                        out_cnt++;
                    end else begin
                        hold_prev = 1'b1;
                        held      = bus_if.out_data;
                    end
                end

                if (done) begin
                    done_cnt++;
                    chk("busy_at_done", 64'(busy), 64'h0);
                end
            end
        end
    end

    // ---------------- job tasks ----------------
    task automatic prep(input int pat);
        wr_t e;
        exp_wr.delete();
        exp_rd.delete();
        exp_out.delete();
        for (int i = 0; i < NWORDS; i++) begin
            e.a = wr_addr(i);
            e.d = in_word(pat, i);
            exp_wr.push_back(e);
        end
        e.a = 16'h0400;
        e.d = 64'h0;
        exp_wr.push_back(e);
        for (int k = 0; k < 2*DIM; k++) begin
            exp_rd.push_back(16'h0300 + 16'(8 * k));
            exp_out.push_back(c_word(pat, k));
        end
        out_cnt  = 0;
        busy_cyc = 0;
        d0       = done_cnt;
    endtask

    task automatic do_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(negedge clk);
        chk("busy_pre_start", 64'(busy), 64'h0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("busy_post_start", 64'(busy), 64'h1);
        @(posedge clk); #1;
    endtask

    task automatic feed(input int pat, input bit stall);
        int n;
        for (int i = 0; i < NWORDS; i++) begin
            if (stall && i > 0 && i % 2 == 0) begin
                bus_if.in_valid = 1'b0;
                repeat (3) @(posedge clk);
                #1;
            end
            bus_if.in_valid = 1'b1;
            bus_if.in_data  = in_word(pat, i);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!bus_if.in_ready && n < 200);
            if (!bus_if.in_ready) begin
                extra("in_ready_timeout", 64'(i));
                bus_if.in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        bus_if.in_valid = 1'b0;
        bus_if.in_data  = '0;
    endtask

    task automatic wait_kick();
        int n;
        n = 0;
        while (!kick_seen && n < 50) begin
            @(posedge clk);
            n++;
        end
        if (!kick_seen) extra("kick_timeout", 64'(n));
    endtask

    task automatic finish_job();
        int n;
        n = 0;
        while (done_cnt == d0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt == d0) extra("done_timeout", 64'(n));
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("done_pulses", 64'(done_cnt - d0), 64'h1);
        chk("busy_after_done", 64'(busy), 64'h0);
        chk("out_words", 64'(out_cnt), 64'(2*DIM));
        chk("wr_left", 64'(exp_wr.size()), 64'h0);
        chk("rd_left", 64'(exp_rd.size()), 64'h0);
        chk("out_left", 64'(exp_out.size()), 64'h0);
`ifdef TPU_SEQ_PERF_EN
        chk("perf_cycles", 64'(perf_cycles), 64'(busy_cyc));
`endif
    endtask

    task automatic run_job(input int pat, input bit stall, input int bp, input bit start_in_wait);
        prep(pat);
        bp_idx  = bp;
        bp_left = 5;
        do_start();
        feed(pat, stall);
        if (start_in_wait) begin
            wait_kick();
            repeat (3) @(posedge clk);
            #1;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        finish_job();
        bp_idx = -1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        bus_if.in_valid = 1'b0;
        bus_if.in_data  = '0;
        #12;
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        chk("rst_in_ready", 64'(bus_if.in_ready), 64'h0);
        chk("rst_out_valid", 64'(bus_if.out_valid), 64'h0);
        chk("rst_out_data", bus_if.out_data, 64'h0);
        chk("rst_bus_r_w", 64'(bus_if.bus_r_w), 64'h0);
        chk("rst_bus_addr", 64'(bus_if.bus_addr), 64'h0);
        chk("rst_bus_wdata", bus_if.bus_wdata, 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run_job(0, 1'b0, -1, 1'b0);
        run_job(1, 1'b1, -1, 1'b0);
        run_job(0, 1'b0, 3, 1'b1);

        // Abort a job during the MatMul wait, then rerun it cleanly
        prep(0);
        do_start();
        feed(0, 1'b0);
        wait_kick();
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_bus_r_w", 64'(bus_if.bus_r_w), 64'h0);
        chk("abort_bus_addr", 64'(bus_if.bus_addr), 64'h0);
        chk("abort_busy", 64'(busy), 64'h0);
        chk("abort_out_valid", 64'(bus_if.out_valid), 64'h0);
        chk("abort_in_ready", 64'(bus_if.in_ready), 64'h0);
        exp_rd.delete();
        exp_out.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        run_job(0, 1'b0, -1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
